proc_control_unit: RTL and testbench



---
 rtl/proc_control_unit_if.sv | 40 ++++
 rtl/proc_control_unit.sv | 150 +++++++++++++++
 tb/tb_proc_control_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_control_unit_if.sv
// ---------------------------------------------------------------------------
// proc_control_unit_if
// Purpose : bundles the start/instruction inputs and every control strobe that
//           runs between the processor control unit and its 9-bit datapath.
// Signals : Run, Din[WIDTH-1:0]           -> into the control unit
//           R0in..R7in, R0out..R7out      <- register load / bus-drive strobes
//           Ain, Gin, Gout, Dinout        <- A/G load, G and Din bus drives
//           AddSub                        <- 0 add, 1 subtract
//           Done, Illegal                 <- completion and illegal-opcode flags
// Modports: master = control unit, slave = datapath side.
// ---------------------------------------------------------------------------
interface proc_control_unit_if #(
  parameter int WIDTH = 9
);
  logic             Run;
  logic [WIDTH-1:0] Din;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic Ain;
  logic Gin;
  logic Gout;
  logic Dinout;
  logic AddSub;
  logic Done;
  logic Illegal;

  modport master (
    input  Run, Din,
    output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    output Ain, Gin, Gout, Dinout, AddSub, Done, Illegal
  );

  modport slave (
    output Run, Din,
    input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  Ain, Gin, Gout, Dinout, AddSub, Done, Illegal
  );
endinterface

// File: rtl/proc_control_unit.sv
// ---------------------------------------------------------------------------
// proc_control_unit
// Purpose : control FSM for the 9-bit processor datapath. Fetches an
//           instruction from Din into IR when Run is high in T0, then walks
//           time slots T1..T3 driving the datapath enables and selects.
//           Instruction: IR[8:6] opcode, IR[5:3] Rx, IR[2:0] Ry.
//           000 mv Rx,Ry | 001 mvi Rx,#Din | 010 add | 011 sub | 1xx illegal
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           cu   - proc_control_unit_if.master (Run, Din in; all strobes out)
// Options : define CU_ILLEGAL_TRAP_EN to raise Illegal alongside Done when an
//           illegal opcode reaches T1; otherwise Illegal is tied low and an
//           illegal opcode is a silent two-cycle NOP.
// ---------------------------------------------------------------------------
module proc_control_unit #(
  parameter int WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  proc_control_unit_if.master   cu
);

  generate
    if (WIDTH != 9) begin : g_width_chk
      $error("proc_control_unit: only WIDTH = 9 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  tstep_t           tstep_q;
  tstep_t           tstep_d;
  logic [WIDTH-1:0] ir_q;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;

  logic [7:0] rin;
  logic [7:0] rout;
  logic       ain;
  logic       gin;
  logic       gout;
  logic       dinout;
  logic       addsub;
  logic       done;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  function automatic logic [7:0] sel(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  // State and IR; IR only loads on an accepted fetch so it stays stable
  // through the remaining slots regardless of what Din does.
  always_ff @(posedge clk) begin
    if (rst) begin
      tstep_q <= T0;
      ir_q    <= '0;
    end else begin
      tstep_q <= tstep_d;
      if (tstep_q == T0 && cu.Run) begin
        ir_q <= cu.Din;
      end
    end
  end

  always_comb begin
    tstep_d = tstep_q;
    rin     = '0;
    rout    = '0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    dinout  = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    unique case (tstep_q)
      T0: begin
        if (cu.Run) begin
          tstep_d = T1;
        end
      end
      T1: begin
        tstep_d = T0;
        case (op)
          3'b000: begin
            rout = sel(ry);
            rin  = sel(rx);
            done = 1'b1;
          end
          3'b001: begin
            dinout = 1'b1;
            rin    = sel(rx);
            done   = 1'b1;
          end
          3'b010, 3'b011: begin
            rout    = sel(rx);
            ain     = 1'b1;
            tstep_d = T2;
          end
          default: begin
            done = 1'b1;
          end
        endcase
      end
      T2: begin
        rout    = sel(ry);
        gin     = 1'b1;
        // op[0] is IR[6]: set only for sub
        addsub  = op[0];
        tstep_d = T3;
      end
      T3: begin
        gout    = 1'b1;
        rin     = sel(rx);
        done    = 1'b1;
        tstep_d = T0;
      end
      default: begin
        tstep_d = T0;
      end
    endcase
  end

  assign {cu.R7in, cu.R6in, cu.R5in, cu.R4in,
          cu.R3in, cu.R2in, cu.R1in, cu.R0in} = rin;
  assign {cu.R7out, cu.R6out, cu.R5out, cu.R4out,
          cu.R3out, cu.R2out, cu.R1out, cu.R0out} = rout;
  assign cu.Ain    = ain;
  assign cu.Gin    = gin;
  assign cu.Gout   = gout;
  assign cu.Dinout = dinout;
  assign cu.AddSub = addsub;
  assign cu.Done   = done;

`ifdef CU_ILLEGAL_TRAP_EN
  assign cu.Illegal = (tstep_q == T1) && ir_q[8];
`else
  assign cu.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_proc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_proc_control_unit
// Drives directed and random instructions into proc_control_unit, compares
// every slot's control word with the instruction table, feeds the strobes
// into a small datapath model and compares its register file with an
// instruction-level model of the four operations.
// ---------------------------------------------------------------------------
module tb_proc_control_unit;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  proc_control_unit_if #(.WIDTH(9)) bus ();

  proc_control_unit #(.WIDTH(9)) u_dut (
    .clk (clk),
    .rst (rst),
    .cu  (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]  rin_v;
  logic [7:0]  rout_v;
  logic [22:0] obs;

  assign rin_v  = {bus.R7in, bus.R6in, bus.R5in, bus.R4in,
                   bus.R3in, bus.R2in, bus.R1in, bus.R0in};
  assign rout_v = {bus.R7out, bus.R6out, bus.R5out, bus.R4out,
                   bus.R3out, bus.R2out, bus.R1out, bus.R0out};
  assign obs    = {rin_v, rout_v, bus.Ain, bus.Gin, bus.Gout, bus.Dinout,
                   bus.AddSub, bus.Done, bus.Illegal};

  // Datapath model driven only by the DUT's strobes
  logic [8:0] dp_r [8];
  logic [8:0] dp_a;
  logic [8:0] dp_g;
  logic [8:0] busv;

  always_comb begin
    busv = '0;
    if (bus.Dinout) busv = bus.Din;
    else if (bus.Gout) busv = dp_g;
    else begin
      for (int i = 0; i < 8; i++) begin
        if (rout_v[i]) busv = dp_r[i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rin_v[i]) dp_r[i] <= busv;
    end
    if (bus.Ain) dp_a <= busv;
    if (bus.Gin) dp_g <= bus.AddSub ? (dp_a - busv) : (dp_a + busv);
  end

  // Instruction-level register model
  logic [8:0] isa_r [8];

  logic [22:0] exp_w [3];
  int          exp_n;

  function automatic logic [22:0] cw(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic ain, input logic gin, input logic gout,
                                     input logic dinout, input logic addsub,
                                     input logic done, input logic ill);
    return {rin, rout, ain, gin, gout, dinout, addsub, done, ill};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [71:0] pack_rf(input logic [8:0] r [8]);
    logic [71:0] v;
    for (int i = 0; i < 8; i++) v[i*9 +: 9] = r[i];
    return v;
  endfunction

  task automatic build_exp(input logic [8:0] ir);
    logic [2:0] op, x, y;
    op = ir[8:6];
    x  = ir[5:3];
    y  = ir[2:0];
    case (op)
      3'd0: begin exp_n = 1; exp_w[0] = cw(oh(x), oh(y), 0, 0, 0, 0, 0, 1, 0); end
      3'd1: begin exp_n = 1; exp_w[0] = cw(oh(x), 8'h00, 0, 0, 0, 1, 0, 1, 0); end
      3'd2, 3'd3: begin
        exp_n    = 3;
        exp_w[0] = cw(8'h00, oh(x), 1, 0, 0, 0, 0, 0, 0);
        exp_w[1] = cw(8'h00, oh(y), 0, 1, 0, 0, (op == 3'd3), 0, 0);
        exp_w[2] = cw(oh(x), 8'h00, 0, 0, 1, 0, 0, 1, 0);
      end
      default: begin exp_n = 1; exp_w[0] = cw(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, TRAP); end
    endcase
  endtask

  task automatic isa_update(input logic [8:0] ir, input logic [8:0] imm);
    logic [2:0] x, y;
    x = ir[5:3];
    y = ir[2:0];
    case (ir[8:6])
      3'd0: isa_r[x] = isa_r[y];
      3'd1: isa_r[x] = imm;
      3'd2: isa_r[x] = isa_r[x] + isa_r[y];
      3'd3: isa_r[x] = isa_r[x] - isa_r[y];
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [22:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
    vectors++;
    assert (($countones({rout_v, bus.Gout, bus.Dinout}) <= 1) && ($countones(rin_v) <= 1)) else begin
      miscompares++;
      $error("FAIL %s_exclusive observed rout=%b gout=%b dinout=%b rin=%b expected at most one driver/loader",
             tag, rout_v, bus.Gout, bus.Dinout, rin_v);
    end
  endtask

  task automatic check_regs(input string tag);
    vectors++;
    assert (pack_rf(dp_r) === pack_rf(isa_r)) else begin
      miscompares++;
      $error("FAIL %s_regs observed=%h expected=%h", tag, pack_rf(dp_r), pack_rf(isa_r));
    end
  endtask

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Entered with the DUT in T0; leaves it in T0 after the instruction.
  task automatic run_instr(input logic [8:0] ir, input logic [8:0] imm, input string tag);
    build_exp(ir);
    check({tag, "/T0"}, '0);
    bus.Run = 1'b1;
    bus.Din = ir;
    step();
    for (int s = 0; s < exp_n; s++) begin
      bus.Din = (s == 0) ? imm : 9'($urandom);
      bus.Run = 1'($urandom_range(0, 1));
      check($sformatf("%s/slot%0d", tag, s + 1), exp_w[s]);
      step();
    end
    isa_update(ir, imm);
    check_regs(tag);
  endtask

  logic [8:0] ir_r, imm_r, saved;

  initial begin
    for (int i = 0; i < 8; i++) isa_r[i] = 'x;
    rst     = 1'b1;
    bus.Run = 1'b1;
    bus.Din = 9'b001_000_000;
    step();
    step();
    check("reset", '0);
    rst     = 1'b0;
    bus.Run = 1'b0;

    run_instr(9'b001_000_000, 9'd5, "mvi_r0_5");
    check_val("r0_eq_5", dp_r[0], 9'd5);
    run_instr(9'b000_001_000, 9'd0, "mv_r1_r0");
    check_val("r1_eq_5", dp_r[1], 9'd5);
    run_instr(9'b010_000_001, 9'd0, "add_r0_r1");
    check_val("r0_eq_10", dp_r[0], 9'd10);
    run_instr(9'b011_000_001, 9'd0, "sub_r0_r1");
    check_val("r0_eq_5b", dp_r[0], 9'd5);
    run_instr(9'b001_000_000, 9'd0, "mvi_r0_0");
    run_instr(9'b001_001_000, 9'd1, "mvi_r1_1");
    run_instr(9'b011_000_001, 9'd0, "sub_wrap");
    check_val("r0_wrap", dp_r[0], 9'h1FF);

    for (int i = 2; i < 8; i++) begin
      run_instr({3'b001, 3'(i), 3'b000}, 9'($urandom), $sformatf("init_r%0d", i));
    end
    run_instr(9'b000_011_011, 9'd0, "mv_r3_r3");
    run_instr(9'b010_010_010, 9'd0, "add_r2_r2");
    run_instr(9'b101_000_000, 9'd0, "illegal_101");

    for (int n = 0; n < 80; n++) begin
      ir_r  = 9'($urandom);
      imm_r = 9'($urandom);
      run_instr(ir_r, imm_r, $sformatf("rnd%0d_%h", n, ir_r));
    end

    // Reset during T2 of an add aborts it
    saved = dp_r[0];
    build_exp(9'b010_000_001);
    check("abort/T0", '0);
    bus.Run = 1'b1;
    bus.Din = 9'b010_000_001;
    step();
    check("abort/T1", exp_w[0]);
    step();
    check("abort/T2", exp_w[1]);
    rst = 1'b1;
    step();
    check("abort/after_rst", '0);
    rst = 1'b0;
    run_instr(9'b001_010_000, 9'd7, "after_abort_mvi");
    check_val("abort_r0_kept", dp_r[0], saved);

    // Reset during T3: the load lands, no Done afterwards
    build_exp(9'b010_011_100);
    check("rst_t3/T0", '0);
    bus.Run = 1'b1;
    bus.Din = 9'b010_011_100;
    step();
    check("rst_t3/T1", exp_w[0]);
    step();
    check("rst_t3/T2", exp_w[1]);
    step();
    check("rst_t3/T3", exp_w[2]);
    rst = 1'b1;
    step();
    isa_update(9'b010_011_100, 9'd0);
    check("rst_t3/after_rst", '0);
    rst     = 1'b0;
    bus.Run = 1'b0;
    step();
    check("rst_t3/idle", '0);
    check_regs("rst_t3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
